bp_be_fpu_recode_pipe: RTL

Pipelined, handshaked successor to the backend FP input recoder. It accepts `els_p` raw IEEE operands with a per-element precision and checks NaN-boxing for single precision. It recodes each operand to double-precision HardFloat recoded format and produces NaN, signalling-NaN, subnormal and optional RISC-V `fclass` information, all through a `latency_p`-deep elastic register pipeline. It sits between the FP register-file read and the FMA/aux units in `bp_be_calculator`, where it replaces the purely combinational recode path so the recode logic can be retimed across real stages under backpressure.

---
 rtl/bp_be_fpu_recode_pipe_if.sv | 36 +++
 rtl/bp_be_fpu_recode_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fpu_recode_pipe_if.sv
// Handshake bundle for bp_be_fpu_recode_pipe.
// slave: recoder side; master: producer/consumer side.
interface bp_be_fpu_recode_pipe_if
  #(parameter int els_p = 3
  , parameter int tag_width_p = 8
  , parameter int dword_width_p = 64
  , parameter int dp_rec_width_gp = 65
  );

    logic                                    v_i;
    logic                                    ready_o;
    logic [els_p-1:0][dword_width_p-1:0]     fp_i;
    logic [els_p-1:0]                        ipr_i;
    logic [tag_width_p-1:0]                  tag_i;

    logic                                    v_o;
    logic                                    ready_i;
    logic [els_p-1:0][dword_width_p-1:0]     fp_o;
    logic [els_p-1:0][dp_rec_width_gp-1:0]   rec_o;
    logic [els_p-1:0]                        nan_o;
    logic [els_p-1:0]                        snan_o;
    logic [els_p-1:0]                        sub_o;
    logic [els_p-1:0][9:0]                   fclass_o;
    logic [tag_width_p-1:0]                  tag_o;

    modport slave
      (input  v_i, fp_i, ipr_i, tag_i, ready_i
      , output ready_o, v_o, fp_o, rec_o, nan_o, snan_o, sub_o, fclass_o, tag_o
      );

    modport master
      (output v_i, fp_i, ipr_i, tag_i, ready_i
      , input  ready_o, v_o, fp_o, rec_o, nan_o, snan_o, sub_o, fclass_o, tag_o
      );

endinterface

// File: rtl/bp_be_fpu_recode_pipe.sv
// Elastic FP input recoder: NaN-box check, recode to double, flags.
// BP_BE_FPU_RECODE_FCLASS_EN adds the fclass mask and its registers.
module bp_be_fpu_recode_pipe
  #(parameter int els_p = 3
  , parameter int latency_p = 2
  , parameter int tag_width_p = 8
  , parameter int dword_width_p = 64
  , parameter int dp_rec_width_gp = 65
  )
  (input  logic clk_i
  , input  logic reset_n_i
  , input  logic flush_i
  , bp_be_fpu_recode_pipe_if.slave io
  );

    typedef struct packed {
        logic [dword_width_p-1:0]   fp;
        logic [dp_rec_width_gp-1:0] rec;
        logic                       nan;
        logic                       snan;
        logic                       sub;
`ifdef BP_BE_FPU_RECODE_FCLASS_EN
        logic [9:0]                 fclass;
`endif
    } el_t;

    typedef struct packed {
        logic [tag_width_p-1:0]                tag;
        logic [els_p-1:0][dword_width_p-1:0]   fp;
        logic [els_p-1:0][dp_rec_width_gp-1:0] rec;
        logic [els_p-1:0]                      nan;
        logic [els_p-1:0]                      snan;
        logic [els_p-1:0]                      sub;
`ifdef BP_BE_FPU_RECODE_FCLASS_EN
        logic [els_p-1:0][9:0]                 fclass;
`endif
    } pl_t;

    function automatic logic [5:0] clz52(input logic [51:0] v);
        logic [5:0] n;
        logic       hit;
        n   = 6'd52;
        hit = 1'b0;
        for (int j = 51; j >= 0; j--) begin
            if (!hit && v[j]) begin
                n   = 6'(51 - j);
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    // Singles are lifted into the double field layout (fraction
    // left-aligned) so one normaliser serves both precisions. The
    // recoded exponent is the true exponent plus 2048.
    function automatic el_t recode_el(input logic [63:0] raw, input logic dp);
        el_t         r;
        logic        boxed;
        logic [31:0] sv;
        logic        s;
        logic [51:0] f;
        logic [51:0] nf;
        logic        e_zero;
        logic        e_max;
        logic        f_zero;
        logic [5:0]  nd;
        logic [11:0] rexp;
        r     = '0;
        boxed = &raw[63:32];
        sv    = boxed ? raw[31:0] : 32'h7FC0_0000;
        if (dp) begin
            s      = raw[63];
            f      = raw[51:0];
            e_zero = (raw[62:52] == 11'd0);
            e_max  = &raw[62:52];
        end else begin
            s      = sv[31];
            f      = {sv[22:0], 29'd0};
            e_zero = (sv[30:23] == 8'd0);
            e_max  = &sv[30:23];
        end
        f_zero = (f == 52'd0);
        nd     = clz52(f);
        nf     = f << (nd + 6'd1);
        if (dp)
            rexp = e_zero ? 12'd1025 - {6'd0, nd} : {1'b0, raw[62:52]} + 12'd1025;
        else
            rexp = e_zero ? 12'd1921 - {6'd0, nd} : {4'd0, sv[30:23]} + 12'd1921;
        r.nan  = e_max & ~f_zero;
        r.snan = r.nan & ~f[51];
        r.sub  = e_zero & ~f_zero;
        r.fp   = dp ? raw : {32'hFFFF_FFFF, sv};
        // Widened single NaNs become the canonical NaN; doubles keep payload.
        if (r.nan)
            r.rec = dp ? {s, 12'hE00, f} : {1'b0, 12'hE00, 1'b1, 51'd0};
        else if (e_max)
            r.rec = {s, 12'hC00, 52'd0};
        else if (e_zero && f_zero)
            r.rec = {s, 64'd0};
        else
            r.rec = {s, rexp, e_zero ? nf : f};
`ifdef BP_BE_FPU_RECODE_FCLASS_EN
        if (r.snan)
            r.fclass[8] = 1'b1;
        else if (r.nan)
            r.fclass[9] = 1'b1;
        else if (e_max)
            r.fclass[s ? 0 : 7] = 1'b1;
        else if (e_zero && f_zero)
            r.fclass[s ? 3 : 4] = 1'b1;
        else if (e_zero)
            r.fclass[s ? 2 : 5] = 1'b1;
        else
            r.fclass[s ? 1 : 6] = 1'b1;
`endif
        return r;
    endfunction

    el_t                  el_w [els_p];
    pl_t                  in_pl;
    pl_t                  pl_r [latency_p];
    logic [latency_p-1:0] v_r;
    logic [latency_p-1:0] load;
    logic                 nxt_go;

    for (genvar g = 0; g < els_p; g++) begin : g_rec
        assign el_w[g] = recode_el(io.fp_i[g], io.ipr_i[g]);
    end

    // Gather per-element results into the stage-0 payload.
    always_comb begin
        in_pl     = '0;
        in_pl.tag = io.tag_i;
        for (int i = 0; i < els_p; i++) begin
            in_pl.fp[i]     = el_w[i].fp;
            in_pl.rec[i]    = el_w[i].rec;
            in_pl.nan[i]    = el_w[i].nan;
            in_pl.snan[i]   = el_w[i].snan;
            in_pl.sub[i]    = el_w[i].sub;
`ifdef BP_BE_FPU_RECODE_FCLASS_EN
            in_pl.fclass[i] = el_w[i].fclass;
`endif
        end
    end

    // Ready ripples back from the consumer: a stage loads when empty or draining.
    always_comb begin
        load   = '0;
        nxt_go = io.ready_i;
        for (int k = latency_p - 1; k >= 0; k--) begin
            load[k] = ~v_r[k] | nxt_go;
            nxt_go  = load[k];
        end
    end

    // Stage valids; reset and flush drop everything in flight.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            v_r <= '0;
        end else begin
            if (load[0]) v_r[0] <= io.v_i;
            for (int k = 1; k < latency_p; k++)
                if (load[k]) v_r[k] <= v_r[k-1];
        end
    end

    // Payloads only move with valid data so idle outputs stay stale.
    always_ff @(posedge clk_i) begin
        if (load[0] && io.v_i) pl_r[0] <= in_pl;
        for (int k = 1; k < latency_p; k++)
            if (load[k] && v_r[k-1]) pl_r[k] <= pl_r[k-1];
    end

    assign io.ready_o = load[0] | ~reset_n_i;
    assign io.v_o     = v_r[latency_p-1];
    assign io.tag_o   = pl_r[latency_p-1].tag;
    assign io.fp_o    = pl_r[latency_p-1].fp;
    assign io.rec_o   = pl_r[latency_p-1].rec;
    assign io.nan_o   = pl_r[latency_p-1].nan;
    assign io.snan_o  = pl_r[latency_p-1].snan;
    assign io.sub_o   = pl_r[latency_p-1].sub;
`ifdef BP_BE_FPU_RECODE_FCLASS_EN
    assign io.fclass_o = pl_r[latency_p-1].fclass;
`else
    assign io.fclass_o = '0;
`endif

endmodule
